char_tx: RTL and testbench

CHAR_TX -- requirements
Module: char_tx

---
 rtl/char_tx.sv | 132 +++++++++++++
 tb/tb_char_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/char_tx.sv
//------------------------------------------------------------------------------
// Module   : char_tx
// Brief    : UART 8N1 burst transmitter; sends NUM_CHARS bytes of a captured
//            128-bit payload, MSB byte first, each byte LSB first.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module char_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_CHARS    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data,
    output logic         dout,
    output logic         busy,
    output logic         done,
    output logic [4:0]   chars_sent
);

    localparam logic [15:0] c_timer_last = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  c_last_char  = 5'(NUM_CHARS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [15:0]    r_bit_timer;
    logic [2:0]     r_bit_idx;
    logic [127:0]   r_shift_buf;
    logic [4:0]     r_chars_sent;
    logic           r_done;

    logic           w_bit_end;
    logic           w_accept;
    logic           w_burst_end;
    logic [7:0]     w_cur_char;

    assign w_bit_end  = (r_bit_timer == c_timer_last);
    assign w_cur_char = r_shift_buf[127:120];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_burst_end  = 1'b0;
        dout         = 1'b1;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = START_BIT;
                end
            end
            START_BIT: begin
                dout = 1'b0;
                if (w_bit_end) begin
                    w_state_next = DATA_BITS;
                end
            end
            DATA_BITS: begin
                dout = w_cur_char[r_bit_idx];
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_next = STOP_BIT;
                end
            end
            STOP_BIT: begin
                if (w_bit_end) begin
                    // No idle gap between characters of the same burst.
                    if (r_chars_sent == c_last_char) begin
                        w_burst_end  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = START_BIT;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_timer  <= 16'd0;
            r_bit_idx    <= 3'd0;
            r_shift_buf  <= 128'd0;
            r_chars_sent <= 5'd0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_burst_end;
            if (w_accept) begin
                r_shift_buf  <= data;
                r_chars_sent <= 5'd0;
                r_bit_timer  <= 16'd0;
                r_bit_idx    <= 3'd0;
            end else if (r_state != IDLE) begin
                r_bit_timer <= w_bit_end ? 16'd0 : r_bit_timer + 16'd1;
                // Index wraps 7 -> 0, ready for the next character.
                if ((r_state == DATA_BITS) && w_bit_end) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
                if ((r_state == STOP_BIT) && w_bit_end) begin
                    r_chars_sent <= r_chars_sent + 5'd1;
                    r_shift_buf  <= {r_shift_buf[119:0], 8'h00};
                end
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign chars_sent = r_chars_sent;

endmodule

`default_nettype wire

// File: tb/tb_char_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_char_tx
// Brief    : Self-checking bench for char_tx with a byte scoreboard fed by a
//            UART line decoder.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_char_tx;

    localparam int CPB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data;
    logic         dout;
    logic         busy;
    logic         done;
    logic [4:0]   chars_sent;

    logic         start1;
    logic [127:0] data1;
    logic         dout1;
    logic         busy1;
    logic         done1;
    logic [4:0]   chars_sent1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    int         done_count = 0;
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = 8'h00;

    char_tx #(.CLKS_PER_BIT(CPB), .NUM_CHARS(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data       (data),
        .dout       (dout),
        .busy       (busy),
        .done       (done),
        .chars_sent (chars_sent)
    );

    char_tx #(.CLKS_PER_BIT(2), .NUM_CHARS(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .data       (data1),
        .dout       (dout1),
        .busy       (busy1),
        .done       (done1),
        .chars_sent (chars_sent1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bytes(input logic [127:0] d);
        for (int k = 0; k < 16; k++) exp_q.push_back(d[127-8*k -: 8]);
    endtask

    // Drives a start pulse and returns at the negedge of the first start-bit cycle.
    task automatic launch(input logic [127:0] d, input bit hold);
        push_bytes(d);
        @(negedge clk);
        data  = d;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("latency_dout", 32'(dout), 32'd0);
        check("latency_busy", 32'(busy), 32'd1);
        check("start_clears_count", 32'(chars_sent), 32'd0);
    endtask

    task automatic wait_done(inout int cyc);
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 2000);
    endtask

    // Line decoder: mid-bit sampling, bit b of a frame sampled at cycle 4b+2.
    always @(negedge clk) begin
        if (!rst) begin
            mon_active = 1'b0;
        end else begin
            if (done) begin
                done_count++;
                check("done_busy_excl", 32'(busy), 32'd0);
            end
            if (!mon_active) begin
                if (dout == 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if ((mon_cnt % CPB == 2) && (mon_cnt >= 6) && (mon_cnt <= 34))
                    mon_byte = {dout, mon_byte[7:1]};
                if (mon_cnt == 38) begin
                    mon_active = 1'b0;
                    check("stop_bit", 32'(dout), 32'd1);
                    check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("rx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [127:0] msg;
        logic [9:0]   frame;
        int           cyc;

        rst    = 1'b0;
        start  = 1'b0;
        data   = '0;
        start1 = 1'b0;
        data1  = '0;

        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_chars_sent", 32'(chars_sent), 32'd0);
        check("rst_dout1", 32'(dout1), 32'd1);
        rst = 1'b1;

        // Single burst of ASCII digits and hex letters.
        msg = "0123456789ABCDEF";
        launch(msg, 1'b0);
        cyc = 0;
        wait_done(cyc);
        check("burst_a_len", 32'(cyc), 32'd640);
        check("burst_a_chars", 32'(chars_sent), 32'd16);
        check("burst_a_busy", 32'(busy), 32'd0);
        check("burst_a_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("done_count_a", 32'(done_count), 32'd1);
        check("chars_held_idle", 32'(chars_sent), 32'd16);

        // Framing of 0xA5, plus a start pulse with new data while busy.
        msg   = {8'hA5, "Hello, world!!!"};
        frame = {1'b1, 8'hA5, 1'b0};
        launch(msg, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            check("frame_a5", 32'(dout), 32'(frame[i/CPB]));
        end
        cyc = 39;
        repeat (61) @(negedge clk);
        cyc   = 100;
        start = 1'b1;
        data  = ~msg;
        @(negedge clk);
        start = 1'b0;
        cyc   = 101;
        wait_done(cyc);
        check("burst_b_len", 32'(cyc), 32'd640);
        @(negedge clk);
        check("done_count_b", 32'(done_count), 32'd2);
        repeat (50) @(negedge clk);
        check("busy_ignored_start", 32'(done_count), 32'd2);
        check("burst_b_idle", 32'(busy), 32'd0);
        check("burst_b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back: start held through done.
        msg = "Back2Back burst!";
        launch(msg, 1'b1);
        push_bytes(msg);
        cyc = 0;
        wait_done(cyc);
        check("b2b_first_len", 32'(cyc), 32'd640);
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_gap_dout", 32'(dout), 32'd0);
        check("b2b_no_gap_busy", 32'(busy), 32'd1);
        check("b2b_count_cleared", 32'(chars_sent), 32'd0);
        cyc = 0;
        wait_done(cyc);
        check("b2b_second_len", 32'(cyc), 32'd640);
        @(negedge clk);
        check("done_count_b2b", 32'(done_count), 32'd4);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-burst, then immediate restart on the first edge.
        msg = "Reset mid-burst.";
        launch(msg, 1'b0);
        repeat (198) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_dout", 32'(dout), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_chars", 32'(chars_sent), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_bytes_left", 32'(exp_q.size()), 32'd11);
        exp_q.delete();
        repeat (3) @(negedge clk);
        msg = "After reset: ok!";
        push_bytes(msg);
        rst   = 1'b1;
        data  = msg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_accept", 32'(dout), 32'd0);
        cyc = 0;
        wait_done(cyc);
        check("post_rst_len", 32'(cyc), 32'd640);
        check("post_rst_chars", 32'(chars_sent), 32'd16);
        @(negedge clk);
        check("no_done_on_abort", 32'(done_count), 32'd5);
        check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

        // Single-character instance, two clocks per bit, byte 0x00.
        data1  = {8'h00, {15{8'hFF}}};
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 20) check("one_char_dout", 32'(dout1), (i < 18) ? 32'd0 : 32'd1);
            check("one_char_done", 32'(done1), (i == 20) ? 32'd1 : 32'd0);
        end
        check("one_char_count", 32'(chars_sent1), 32'd1);
        check("one_char_busy", 32'(busy1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
